// File: rtl/note_judge.sv
// Per-lane hit judge: classifies notes as HIT/MISS and stray presses as BAD; tracks score/combo/lives.
// Optional combo bonus scoring enabled by defining NOTE_JUDGE_COMBO_BONUS_EN.
module note_judge #(
    parameter int unsigned SCORE_W      = 10,
    parameter int unsigned SCORE_MAX    = 999,
    parameter int unsigned COMBO_W      = 7,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned COMBO_THRESH = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               reachEnd,
    input  logic               pressed,
    input  logic               restart,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [1:0]         lives,
    output logic               hitPulse,
    output logic               missPulse,
    output logic               badPulse,
    output logic               gameOver
);

    typedef enum logic [1:0] {StIdle, StArmed, StJudged, StOver} state_e;

`ifdef NOTE_JUDGE_COMBO_BONUS_EN
    localparam bit BonusEn = 1'b1;
`else
    localparam bit BonusEn = 1'b0;
`endif

    localparam logic [COMBO_W-1:0] ComboMax    = '1;
    localparam logic [SCORE_W:0]   ScoreMaxExt = (SCORE_W + 1)'(SCORE_MAX);
    localparam logic [1:0]         LivesInit   = 2'(LIVES);

    state_e             state_q, state_d;
    logic               pressed_q, pressed_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [1:0]         lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               bad_q, bad_d;
    logic               game_over_q, game_over_d;

    logic             rise;
    logic             do_hit, do_miss, do_bad;
    logic [1:0]       pts;
    logic [SCORE_W:0] score_sum;

    always_comb begin
        rise      = pressed & ~pressed_q;
        pressed_d = pressed;
        // pts uses the combo value before this hit's increment
        pts       = (BonusEn && (32'(combo_q) >= COMBO_THRESH)) ? 2'd2 : 2'd1;
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);

        state_d = state_q;
        score_d = score_q;
        combo_d = combo_q;
        lives_d = lives_q;
        do_hit  = 1'b0;
        do_miss = 1'b0;
        do_bad  = 1'b0;

        if (restart) begin
            state_d = StIdle;
            score_d = '0;
            combo_d = '0;
            lives_d = LivesInit;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (reachEnd) begin
                        do_hit  = rise;
                        state_d = rise ? StJudged : StArmed;
                    end else begin
                        do_bad = rise;
                    end
                end
                StArmed: begin
                    // a press on the closing edge is ignored: the note is already missed
                    if (!reachEnd) begin
                        do_miss = 1'b1;
                        state_d = (lives_q == 2'd1) ? StOver : StIdle;
                    end else if (rise) begin
                        do_hit  = 1'b1;
                        state_d = StJudged;
                    end
                end
                StJudged: begin
                    if (!reachEnd) state_d = StIdle;
                end
                default: ;
            endcase

            if (do_hit) begin
                score_d = (score_sum > ScoreMaxExt) ? ScoreMaxExt[SCORE_W-1:0]
                                                    : score_sum[SCORE_W-1:0];
                combo_d = (combo_q == ComboMax) ? combo_q : combo_q + 1'b1;
            end
            if (do_miss) begin
                combo_d = '0;
                lives_d = lives_q - 2'd1;
            end
            if (do_bad) combo_d = '0;
        end

        hit_d       = do_hit;
        miss_d      = do_miss;
        bad_d       = do_bad;
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            pressed_q   <= 1'b0;
            score_q     <= '0;
            combo_q     <= '0;
            lives_q     <= LivesInit;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            bad_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pressed_q   <= pressed_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            lives_q     <= lives_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            bad_q       <= bad_d;
            game_over_q <= game_over_d;
        end
    end

    assign score     = score_q;
    assign combo     = combo_q;
    assign lives     = lives_q;
    assign hitPulse  = hit_q;
    assign missPulse = miss_q;
    assign badPulse  = bad_q;
    assign gameOver  = game_over_q;

endmodule
